// File: rtl/prog_loader.sv
// prog_loader: UART (8N1, LSB first) fed loader that writes NUM_BYTES bytes into the program RAM.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte per session.
module prog_loader #(
  parameter int CLKS_PER_BIT = 16,
  parameter int NUM_BYTES    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rx,
  output logic       prog_mode,
  output logic       prog_clk,
  output logic [3:0] prog_addr,
  output logic [7:0] program_data,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [9:0] BIT_LAST  = 10'(CLKS_PER_BIT - 1);
  localparam logic [9:0] HALF_LAST = 10'((CLKS_PER_BIT / 2) - 1);
  localparam logic [3:0] ADDR_LAST = 4'(NUM_BYTES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT, S_START, S_DATA, S_STOP, S_FERR, S_W0, S_W1, S_W2, S_FIN
  } state_t;

  state_t     r_state, w_state_nx;
  logic       r_rx_meta, r_rx_sync, r_rx_prev;
  logic [9:0] r_cnt;
  logic [2:0] r_bitcnt;
  logic [7:0] r_shift;
  logic       r_prog_mode, r_prog_clk, r_busy, r_done, r_err;
  logic [3:0] r_addr;
  logic [7:0] r_data;
  logic       w_rxs, w_fall, w_tick_half, w_tick_bit;
  logic       w_ck_phase, w_ck_bad;

  assign w_rxs       = r_rx_sync;
  assign w_fall      = r_rx_prev & ~r_rx_sync;
  assign w_tick_half = (r_cnt == HALF_LAST);
  assign w_tick_bit  = (r_cnt == BIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam logic CK_EN = 1'b1;
  logic       r_ck_phase;
  logic [7:0] r_sum;

  assign w_ck_phase = r_ck_phase;
  assign w_ck_bad   = (r_shift != r_sum) | ~w_rxs;

  // Running sum of written bytes; the byte after the last write is the checksum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ck_phase <= 1'b0;
      r_sum      <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_ck_phase <= 1'b0;
      r_sum      <= '0;
    end else if (w_state_nx == S_W0) begin
      r_sum <= r_sum + r_shift;
    end else if (r_state == S_W2 && r_addr == ADDR_LAST) begin
      r_ck_phase <= 1'b1;
    end
  end
`else
  localparam logic CK_EN = 1'b0;
  assign w_ck_phase = 1'b0;
  assign w_ck_bad   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nx = S_WAIT;
      S_WAIT:  if (w_fall) w_state_nx = S_START;
      S_START: if (w_tick_half) w_state_nx = w_rxs ? S_WAIT : S_DATA;
      S_DATA:  if (w_tick_bit && r_bitcnt == 3'd7) w_state_nx = S_STOP;
      S_STOP: begin
        if (w_tick_bit) begin
          if (w_ck_phase)  w_state_nx = S_FIN;
          else if (w_rxs)  w_state_nx = S_W0;
          else             w_state_nx = S_FERR;
        end
      end
      S_FERR:  if (w_rxs) w_state_nx = S_WAIT;
      S_W0:    w_state_nx = S_W1;
      S_W1:    w_state_nx = S_W2;
      S_W2:    w_state_nx = (r_addr == ADDR_LAST && !CK_EN) ? S_FIN : S_WAIT;
      S_FIN:   w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Data is loaded on entry to W0 so it is stable a full cycle before prog_clk rises in W1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_prog_mode <= 1'b0;
      r_prog_clk  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
    end else begin
      r_prog_clk <= (w_state_nx == S_W1);
      r_done     <= (w_state_nx == S_FIN);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy      <= 1'b1;
            r_prog_mode <= 1'b1;
            r_addr      <= '0;
            r_err       <= 1'b0;
          end
        end
        S_START: begin
          r_cnt    <= w_tick_half ? '0 : r_cnt + 10'd1;
          r_bitcnt <= '0;
        end
        S_DATA: begin
          if (w_tick_bit) begin
            r_cnt    <= '0;
            r_shift  <= {w_rxs, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
          end else begin
            r_cnt <= r_cnt + 10'd1;
          end
        end
        S_STOP: begin
          if (w_tick_bit) begin
            r_cnt <= '0;
            if (w_ck_phase ? w_ck_bad : ~w_rxs) r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 10'd1;
          end
        end
        S_W2: if (r_addr != ADDR_LAST) r_addr <= r_addr + 4'd1;
        default: r_cnt <= '0;
      endcase
      if (w_state_nx == S_W0) r_data <= r_shift;
      if (w_state_nx == S_FIN) begin
        r_busy      <= 1'b0;
        r_prog_mode <= 1'b0;
        r_addr      <= '0;
      end
    end
  end

  assign prog_mode    = r_prog_mode;
  assign prog_clk     = r_prog_clk;
  assign prog_addr    = r_addr;
  assign program_data = r_data;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table-driven framing/start session plus model-checked sessions.
module tb_prog_loader;
  localparam int CPB = 16;
  localparam int NB  = 16;

  logic       clk = 1'b0;
  logic       rst, start, rx;
  logic       prog_mode, prog_clk, busy, done, err;
  logic [3:0] prog_addr;
  logic [7:0] program_data;

  prog_loader #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .rx(rx),
    .prog_mode(prog_mode), .prog_clk(prog_clk), .prog_addr(prog_addr),
    .program_data(program_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  // Write monitor: records every RAM write and counts timing/protocol violations.
  logic [3:0] wa_q[$];
  logic [7:0] wd_q[$];
  int         done_cnt = 0;
  logic       err_at_done = 1'b0;
  int         timing_bad = 0;
  logic       prev_pclk = 1'b0;
  logic [3:0] prev_addr = '0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    if (prog_clk) begin
      wa_q.push_back(prog_addr);
      wd_q.push_back(program_data);
      if (!prog_mode || prev_pclk || prev_addr !== prog_addr || prev_data !== program_data)
        timing_bad++;
    end
    if (prev_pclk && !prog_clk && (prev_addr !== prog_addr || prev_data !== program_data))
      timing_bad++;
    if (done) begin
      done_cnt++;
      err_at_done = err;
    end
    prev_pclk = prog_clk;
    prev_addr = prog_addr;
    prev_data = program_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_ok);
    rx = 1'b0;
    tick(CPB);
    for (int b = 0; b < 8; b++) begin
      rx = d[b];
      tick(CPB);
    end
    rx = stop_ok;
    tick(CPB);
    rx = 1'b1;
    tick(2 * CPB);
  endtask

  logic [7:0] tx_d[40];
  logic       tx_ok[40];
  int         tx_n;
  int         ck_bias = 0;

  // Reference model: bytes with a good stop bit land at consecutive addresses;
  // any framing error (or bad checksum) leaves err set at done.
  task automatic run_session(input string tag);
    logic [7:0] exp_q[$];
    logic       exp_err;
    logic [7:0] sum;
    int         n0, d0;
    exp_err = 1'b0;
    sum     = '0;
    n0      = wa_q.size();
    d0      = done_cnt;
    pulse_start();
    tick(CPB);
    for (int i = 0; i < tx_n; i++) begin
      send_byte(tx_d[i], tx_ok[i]);
      if (!tx_ok[i]) exp_err = 1'b1;
      else if (exp_q.size() < NB) begin
        exp_q.push_back(tx_d[i]);
        sum = sum + tx_d[i];
      end
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(sum + 8'(ck_bias), 1'b1);
    if (ck_bias != 0) exp_err = 1'b1;
`endif
    tick(4);
    check({tag, "_nwr"}, wa_q.size() - n0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (n0 + i < wa_q.size()) begin
        check($sformatf("%s_addr%0d", tag, i), wa_q[n0 + i], i);
        check($sformatf("%s_data%0d", tag, i), wd_q[n0 + i], exp_q[i]);
      end
    end
    check({tag, "_done"}, done_cnt - d0, 1);
    check({tag, "_err_done"}, err_at_done, exp_err);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_pmode"}, prog_mode, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  typedef struct packed {
    logic [7:0] data;
    logic       stop;
    logic       pstart;
    logic       exp_wr;
    logic [3:0] exp_addr;
  } vec_t;

  vec_t vt[17];

  initial begin
    int         n0, d0, nbad;
    logic [7:0] tsum;

    vt[0] = '{data: 8'h55, stop: 1'b0, pstart: 1'b0, exp_wr: 1'b0, exp_addr: 4'd0};
    vt[1] = '{data: 8'hAA, stop: 1'b1, pstart: 1'b0, exp_wr: 1'b1, exp_addr: 4'd0};
    for (int i = 2; i < 17; i++)
      vt[i] = '{data: 8'(8'hC0 + i), stop: 1'b1, pstart: (i == 7), exp_wr: 1'b1,
                exp_addr: 4'(i - 1)};

    rst = 1'b1; start = 1'b0; rx = 1'b1;
    tick(3);
    check("rst_pmode", prog_mode, 0);
    check("rst_pclk", prog_clk, 0);
    check("rst_addr", prog_addr, 0);
    check("rst_data", program_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    tick(4);

    // Reset in the middle of receiving a byte
    pulse_start();
    tick(CPB);
    rx = 1'b0;
    tick(3 * CPB);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_pmode", prog_mode, 1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_pmode", prog_mode, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_pclk", prog_clk, 0);
    rx = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
    n0 = wa_q.size();
    send_byte(8'h5A, 1'b1);
    check("idle_byte_nwr", wa_q.size() - n0, 0);
    check("idle_byte_busy", busy, 0);

    // Nominal load 0x10..0x1F
    tx_n = 16;
    for (int i = 0; i < 16; i++) begin
      tx_d[i]  = 8'(8'h10 + i);
      tx_ok[i] = 1'b1;
    end
    run_session("nom");

    // Framing error first, start pulse mid-session, table-driven
    n0 = wa_q.size();
    d0 = done_cnt;
    tsum = '0;
    pulse_start();
    tick(CPB);
    for (int i = 0; i < 17; i++) begin
      int nb;
      if (vt[i].pstart) begin
        pulse_start();
        check($sformatf("tbl%0d_start_err", i), err, 1);
        check($sformatf("tbl%0d_start_busy", i), busy, 1);
        tick(CPB);
      end
      nb = wa_q.size();
      send_byte(vt[i].data, vt[i].stop);
      if (vt[i].exp_wr) tsum = tsum + vt[i].data;
      check($sformatf("tbl%0d_nwr", i), wa_q.size() - nb, vt[i].exp_wr);
      if (vt[i].exp_wr && wa_q.size() > nb) begin
        check($sformatf("tbl%0d_addr", i), wa_q[nb], vt[i].exp_addr);
        check($sformatf("tbl%0d_data", i), wd_q[nb], vt[i].data);
      end
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(tsum, 1'b1);
`endif
    tick(4);
    check("tbl_total_wr", wa_q.size() - n0, 16);
    check("tbl_done", done_cnt - d0, 1);
    check("tbl_err_done", err_at_done, 1);
    check("tbl_pmode", prog_mode, 0);

    // Glitch on rx while waiting for a start bit
    pulse_start();
    tick(CPB);
    n0 = wa_q.size();
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(2 * CPB);
    check("glitch_nwr", wa_q.size() - n0, 0);
    check("glitch_busy", busy, 1);
    send_byte(8'h3C, 1'b1);
    check("glitch_next_nwr", wa_q.size() - n0, 1);
    if (wa_q.size() > n0) begin
      check("glitch_next_addr", wa_q[n0], 0);
      check("glitch_next_data", wd_q[n0], 8'h3C);
    end
    rst = 1'b1;
    #1;
    check("abort_pmode", prog_mode, 0);
    tick(2);
    rst = 1'b0;
    tick(4);

`ifdef PROG_LOADER_CHECKSUM_EN
    tx_n = 16;
    for (int i = 0; i < 16; i++) begin
      tx_d[i]  = 8'(i + 1);
      tx_ok[i] = 1'b1;
    end
    ck_bias = 0;
    run_session("ck_good");
    ck_bias = 1;
    run_session("ck_bad");
    ck_bias = 0;
`endif

    // Randomised sessions with occasional framing errors
    for (int s = 0; s < 3; s++) begin
      int good;
      good = 0;
      nbad = 0;
      tx_n = 0;
      while (good < NB) begin
        tx_d[tx_n] = 8'($urandom);
        tx_ok[tx_n] = !(nbad < 4 && $urandom_range(0, 7) == 0);
        if (tx_ok[tx_n]) good++;
        else nbad++;
        tx_n++;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ck_bias = int'($urandom_range(0, 1));
`endif
      run_session($sformatf("rnd%0d", s));
    end

    check("write_timing", timing_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
